video_stream_out: RTL
=====================

# video_stream_out

Pixel-clock video output stage that sits directly downstream of the framebuffer's output data stream. It generates raster timing for a parameterised mode and issues the frame-start request and per-pixel stream enable to the framebuffer. It consumes the 16-bit RGB565 stream and drives registered hsync/vsync/DE plus 8-bit-per-channel colour. It blanks any frame whose preload did not finish in time, and reports underflow and skipped frames as status.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync

Ports:
- clk_pix  in  1  pixel clock; the only clock
- reset_i  in  1  synchronous, active-high reset
- stream_start_frame_o  out  1  one-cycle pulse requesting the framebuffer to restart/preload from its base address
- stream_preloading_i  in  1  framebuffer still preloading
- stream_ena_o  out  1  pop one pixel this cycle
- stream_data_i  in  16  RGB565 pixel, valid in the same cycle as stream_ena_o (show-ahead)
- stream_err_underflow_i  in  1  framebuffer underflow flag
- vga_hsync_o, vga_vsync_o, vga_de_o  out  1 each  registered sync and data enable
- vga_r_o, vga_g_o, vga_b_o  out  8 each  registered colour
- underflow_o  out  1  sticky underflow status for the current frame
- frame_skip_count_o  out  8  saturating count of blanked frames

## Operation
**Counters and active region**
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- hcount runs 0..H_TOTAL-1; vcount increments when hcount wraps and itself wraps at V_TOTAL-1.
- Region order on both axes: active, front porch, sync, back porch. Active means hcount<H_ACTIVE and vcount<V_ACTIVE.
- Sync is asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, and likewise vertically. Output level = POL when asserted, !POL otherwise.

**Frame start request**
- stream_start_frame_o is registered. It is high for exactly one cycle, the cycle after counters equal (hcount=0, vcount=V_ACTIVE), i.e. the start of vertical blanking.
- This gives the framebuffer the whole blanking interval to preload.

**State machine**
- States: BLANK, SHOW, SKIP.
- The decision is made on the cycle counters wrap to (0,0):
  - stream_preloading_i=0 -> SHOW
  - stream_preloading_i=1 -> SKIP; frame_skip_count_o increments, saturating at 255
- SHOW/SKIP -> BLANK when vcount reaches V_ACTIVE.
- Reset state is BLANK.

**Stream and pixel behaviour**
- stream_ena_o = (state==SHOW) && active. It is combinational from registers only, with no input-to-output path.
- Exactly H_ACTIVE*V_ACTIVE enables are issued per SHOW frame and none in SKIP or BLANK.
- SKIP frames still assert DE over the active area, with black pixels.
- Colour expansion: r={d[15:11],d[15:13]}, g={d[10:5],d[10:9]}, b={d[4:0],d[4:2]}.
- Outside SHOW-active, colour outputs are 0.

**Underflow status**
- underflow_o is set when stream_err_underflow_i=1 in any cycle with state SHOW.
- It is cleared on the stream_start_frame_o cycle. Set has priority over clear in the same cycle.

## Timing
- Reset values:
  - hcount=0, vcount=V_ACTIVE, state BLANK
  - stream_start_frame_o=0, stream_ena_o=0
  - vga_de_o=0, rgb=0
  - vga_hsync_o=!HS_POL, vga_vsync_o=!VS_POL
  - underflow_o=0, frame_skip_count_o=0
- First stream_start_frame_o: the first cycle after reset release. Consequently the first frame after reset always starts blanking-first.
- Latency: sync, DE and rgb are registered one cycle after the counter value that produced them. Pixel data is sampled at the edge ending the stream_ena_o cycle, so rgb and DE are aligned.
- Reset asserted mid-frame: all outputs return to reset values in the next cycle; no further stream_ena_o pulses are issued; status is cleared.
- stream_preloading_i is sampled only at the (0,0) decision. Its later deassertion does not rescue a SKIP frame.

## Test plan
- Mode H=4/1/1/1, V=3/1/1/1. Reset 2 cycles, then run 3 frames:
  - stream_start_frame_o pulses at cycles 1, 43, 85 (frame period = 7×6 = 42);
  - hsync width is 1 every 7 cycles;
  - vsync width is 7 cycles.
- Same mode with preloading_i=0: exactly 12 stream_ena_o per frame, each inside vga_de_o-1 windows; DE high 12 cycles per frame.
- Data mapping:
  - stream_data_i=16'hF800 -> rgb FF/00/00
  - 16'h07E0 -> 00/FF/00
  - 16'h001F -> 00/00/FF
  - 16'h8410 -> 84/82/84
- preloading_i held 1 across (0,0): no stream_ena_o, DE high with rgb=0, frame_skip_count_o 0->1. Hold for 300 frames: count saturates at 255.
- Pulse stream_err_underflow_i during SHOW: underflow_o=1 until the next stream_start_frame_o cycle, then 0. The same pulse during BLANK leaves underflow_o=0.
- Assert reset_i while vcount=1 in SHOW: next cycle all outputs are at reset values, stream_ena_o stays 0, and stream_start_frame_o pulses in the first cycle after release.

Source files
------------

// File: rtl/video_stream_out.sv
// video_stream_out
//
// Pixel-clock video output stage placed directly after the framebuffer's
// output stream. It generates raster timing for a parameterised mode, asks
// the framebuffer to preload at the start of vertical blanking, pops one
// RGB565 pixel per visible pixel, and drives registered sync/DE/colour.
// A frame whose preload has not finished by the first visible pixel is
// shown as black (DE still asserted) and counted as skipped.
//
// Ports:
//   clk_pix                 pixel clock, the only clock
//   reset_i                 synchronous active-high reset
//   stream_start_frame_o    one-cycle request to restart/preload the framebuffer
//   stream_preloading_i     framebuffer still preloading
//   stream_ena_o            pop one pixel this cycle (driven from registers only)
//   stream_data_i [15:0]    RGB565 pixel, valid in the stream_ena_o cycle
//   stream_err_underflow_i  framebuffer underflow flag
//   vga_hsync_o/vsync_o/de_o registered sync and data enable
//   vga_r_o/g_o/b_o [7:0]   registered 8-bit colour
//   underflow_o             sticky underflow status for the current frame
//   frame_skip_count_o[7:0] saturating count of blanked frames

module video_stream_out #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk_pix,
    input  logic        reset_i,
    output logic        stream_start_frame_o,
    input  logic        stream_preloading_i,
    output logic        stream_ena_o,
    input  logic [15:0] stream_data_i,
    input  logic        stream_err_underflow_i,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_de_o,
    output logic [7:0]  vga_r_o,
    output logic [7:0]  vga_g_o,
    output logic [7:0]  vga_b_o,
    output logic        underflow_o,
    output logic [7:0]  frame_skip_count_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        BLANK,
        SHOW,
        SKIP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;

    logic h_wrap;
    logic frame_wrap;
    logic blank_entry;
    logic active;
    logic hsync_on;
    logic vsync_on;

    assign h_wrap      = (hcount == H_LAST);
    assign frame_wrap  = h_wrap && (vcount == V_LAST);
    // The last active line is ending: the next position starts vertical blanking.
    assign blank_entry = h_wrap && (vcount == V_ACT_LAST);
    assign active      = (hcount < H_ACT) && (vcount < V_ACT);
    assign hsync_on    = (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
    assign vsync_on    = (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);

    // Pop only from registered state, so there is no input-to-output path.
    assign stream_ena_o = (state == SHOW) && active;

    // Raster counters. Reset parks them at the start of vertical blanking so
    // the first frame after reset always begins with a full preload interval.
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            hcount <= '0;
            vcount <= V_ACT;
        end else if (h_wrap) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            state <= BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // The show/skip decision is taken on the edge that moves the counters to
    // (0,0), so the first visible pixel already sees the new state.
    always_comb begin
        state_nxt = state;
        case (state)
            BLANK: begin
                if (frame_wrap) begin
                    state_nxt = stream_preloading_i ? SKIP : SHOW;
                end
            end
            SHOW, SKIP: begin
                if (blank_entry) begin
                    state_nxt = BLANK;
                end
            end
            default: state_nxt = BLANK;
        endcase
    end

    // Registered video outputs, one cycle behind the counter position that
    // produced them; pixel data is captured at the end of its enable cycle.
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            vga_hsync_o          <= ~HS_POL;
            vga_vsync_o          <= ~VS_POL;
            vga_de_o             <= 1'b0;
            vga_r_o              <= '0;
            vga_g_o              <= '0;
            vga_b_o              <= '0;
            stream_start_frame_o <= 1'b0;
        end else begin
            vga_hsync_o          <= hsync_on ? HS_POL : ~HS_POL;
            vga_vsync_o          <= vsync_on ? VS_POL : ~VS_POL;
            vga_de_o             <= active;
            stream_start_frame_o <= (hcount == '0) && (vcount == V_ACT);
            if (stream_ena_o) begin
                vga_r_o <= {stream_data_i[15:11], stream_data_i[15:13]};
                vga_g_o <= {stream_data_i[10:5],  stream_data_i[10:9]};
                vga_b_o <= {stream_data_i[4:0],   stream_data_i[4:2]};
            end else begin
                vga_r_o <= '0;
                vga_g_o <= '0;
                vga_b_o <= '0;
            end
        end
    end

    // Status: underflow is sticky for the frame and cleared by the frame-start
    // request; a new underflow in the same cycle wins. Skipped frames are
    // counted at the decision edge and saturate.
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            underflow_o        <= 1'b0;
            frame_skip_count_o <= '0;
        end else begin
            if ((state == SHOW) && stream_err_underflow_i) begin
                underflow_o <= 1'b1;
            end else if (stream_start_frame_o) begin
                underflow_o <= 1'b0;
            end
            if ((state == BLANK) && (state_nxt == SKIP) &&
                (frame_skip_count_o != 8'hFF)) begin
                frame_skip_count_o <= frame_skip_count_o + 8'd1;
            end
        end
    end

endmodule
